// File: rtl/mult_div_if.sv
// Request/response bundle between the control unit and the multiply/divide engine.
//   master (control unit): drives start, op, a, b; observes busy, done, div0, hi, lo.
//   slave  (engine)      : observes start, op, a, b; drives busy, done, div0, hi, lo.
interface mult_div_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div0;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, div0, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, div0, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (Booth radix-2) / divide (restoring) engine.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : mult_div_if slave port
//           start/op/a/b sampled in IDLE (op: 0 = MULT, 1 = DIV)
//           busy high outside IDLE, done pulses with hi/lo valid,
//           div0 pulses for DIV with b == 0
//           MULT: {hi, lo} = a * b ; DIV: lo = quotient, hi = remainder
module mult_div_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic       clk,
    input  logic       reset,
    mult_div_if.slave  bus
);

    localparam int unsigned W2 = 2 * WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE,
        S_ERR
    } state_t;

    state_t             state;
    state_t             state_n;

    logic [W2-1:0]      work;      // MULT: {acc, q}   DIV: {rem, quo}
    logic               q_m1;      // Booth q_-1 bit
    logic [WIDTH-1:0]   mcand;     // MULT: multiplicand a   DIV: |b|
    logic               op_q;
    logic               neg_q;
    logic               neg_r;
    logic [CNT_W-1:0]   cnt;

    logic               busy_q;
    logic               done_q;
    logic               div0_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic               load;
    logic               step;
    logic               fix;

    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [W2-1:0]      work_step;
    logic [WIDTH-1:0]   hi_fix;
    logic [WIDTH-1:0]   lo_fix;

    // Booth / restoring datapath intermediates
    logic [WIDTH:0]     acc_ext;
    logic [WIDTH:0]     m_ext;
    logic [WIDTH:0]     booth_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH+1:0]   trial;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and datapath control
    always_comb begin
        state_n = state;
        load    = 1'b0;
        step    = 1'b0;
        fix     = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.op && (bus.b == '0)) begin
                        state_n = S_ERR;
                    end else begin
                        state_n = S_RUN;
                        load    = 1'b1;
                    end
                end
            end
            S_RUN: begin
                step = 1'b1;
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    state_n = S_FIX;
                end
            end
            S_FIX: begin
                fix     = 1'b1;
                state_n = S_DONE;
            end
            S_DONE:  state_n = S_IDLE;
            S_ERR:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Operand magnitudes; -0x80000000 wraps to itself, read as unsigned 2^31
    always_comb begin
        abs_a = bus.a[WIDTH-1] ? -bus.a : bus.a;
        abs_b = bus.b[WIDTH-1] ? -bus.b : bus.b;
    end

    // One iteration of the selected algorithm
    always_comb begin
        acc_ext   = {work[W2-1], work[W2-1:WIDTH]};
        m_ext     = {mcand[WIDTH-1], mcand};
        booth_sum = acc_ext;
        rem_sh    = {work[W2-1:WIDTH], work[WIDTH-1]};
        trial     = {1'b0, rem_sh} - {2'b00, mcand};
        work_step = work;
        if (!op_q) begin
            // 33-bit add keeps the true sign when the multiplicand is -2^31
            case ({work[0], q_m1})
                2'b10:   booth_sum = acc_ext - m_ext;
                2'b01:   booth_sum = acc_ext + m_ext;
                default: booth_sum = acc_ext;
            endcase
            work_step = {booth_sum, work[WIDTH-1:1]};
        end else begin
            if (trial[WIDTH+1]) begin
                work_step = {rem_sh[WIDTH-1:0], work[WIDTH-2:0], 1'b0};
            end else begin
                work_step = {trial[WIDTH-1:0], work[WIDTH-2:0], 1'b1};
            end
        end
    end

    // Sign correction applied on the FIX -> DONE edge
    always_comb begin
        if (!op_q) begin
            hi_fix = work[W2-1:WIDTH];
            lo_fix = work[WIDTH-1:0];
        end else begin
            hi_fix = neg_r ? -work[W2-1:WIDTH] : work[W2-1:WIDTH];
            lo_fix = neg_q ? -work[WIDTH-1:0]  : work[WIDTH-1:0];
        end
    end

    // Working registers and result
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            work  <= '0;
            q_m1  <= 1'b0;
            mcand <= '0;
            op_q  <= 1'b0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            cnt   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            if (load) begin
                op_q <= bus.op;
                q_m1 <= 1'b0;
                cnt  <= '0;
                if (bus.op) begin
                    work  <= {{WIDTH{1'b0}}, abs_a};
                    mcand <= abs_b;
                    neg_q <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                    neg_r <= bus.a[WIDTH-1];
                end else begin
                    work  <= {{WIDTH{1'b0}}, bus.b};
                    mcand <= bus.a;
                    neg_q <= 1'b0;
                    neg_r <= 1'b0;
                end
            end else if (step) begin
                work <= work_step;
                q_m1 <= work[0];
                cnt  <= cnt + CNT_W'(1);
            end
            if (fix) begin
                hi_q <= hi_fix;
                lo_q <= lo_fix;
            end
        end
    end

    // Status flags registered from the next state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            div0_q <= 1'b0;
        end else begin
            busy_q <= (state_n != S_IDLE);
            done_q <= (state_n == S_DONE);
            div0_q <= (state_n == S_ERR);
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.div0 = div0_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative signed multiply/divide engine behind the control unit's Div_Mult_Ctrl / DIV0 / HI-LO write interface.
- Sequences a radix-2 Booth multiplier and a restoring divider over a single shared 64-bit working register.
- Presents results on hi/lo for the HI and LO registers, with a one-cycle done pulse.
- Flags division by zero for the exception path (vector 253–255 selection is done in the control unit).

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported and verified.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  start request (Div_Mult_Ctrl); sampled only in IDLE.
- op  in  1  0 = MULT, 1 = DIV; sampled with start.
- a  in  WIDTH  multiplicand / dividend (A register); sampled with start.
- b  in  WIDTH  multiplier / divisor (B register); sampled with start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse; hi/lo valid, drives HI/LO write enable.
- div0  out  1  one-cycle pulse on DIV with b == 0.
- hi  out  WIDTH  MULT: product[63:32]; DIV: remainder.
- lo  out  WIDTH  MULT: product[31:0]; DIV: quotient.

Behaviour:
- Reset (reset == 0, asynchronous):
  - state = IDLE; counter = 0; working registers = 0.
  - busy = 0, done = 0, div0 = 0, hi = 0, lo = 0.
  - Any operation in progress is aborted; no done pulse and no partial result are produced.
- States and transitions: IDLE, RUN, FIX, DONE, ERR.
- IDLE:
  - start = 1, op = 1, b == 0 → ERR.
  - start = 1 otherwise → RUN; operands latched; counter = 0.
  - Otherwise stay in IDLE.
- RUN: one iteration per clock; counter increments; after exactly WIDTH iterations → FIX.
- FIX: result sign correction; hi/lo registered on the FIX→DONE edge.
- DONE: done = 1 for this cycle only; next edge → IDLE.
- ERR: div0 = 1 for this cycle only; hi/lo unchanged; done stays 0; next edge → IDLE.
- Latency: with start sampled at edge E0, done is high in the cycle after edge E0+WIDTH+1. That is 33 cycles for WIDTH = 32, identical for MULT and DIV. busy falls after edge E0+WIDTH+2. A new start is accepted no earlier than that edge.
- start asserted while busy is ignored and does not queue. op, a and b may change freely after the sampling edge.
- MULT arithmetic:
  - Booth radix-2 on a 65-bit {acc, q, q_-1} register.
  - Each step: add/subtract the multiplicand per {q0, q_-1}, then arithmetic shift right by 1.
  - Result: {hi, lo} = signed(a) × signed(b), full 64 bits, never overflows.
  - a = 0x80000000 is handled correctly through sign extension to 33 bits.
- DIV arithmetic:
  - Restoring division on magnitudes |a| and |b|; |0x80000000| is treated as unsigned 2^31.
  - Quotient truncates toward zero. Quotient is negated when sign(a) ≠ sign(b).
  - Remainder takes the sign of a.
  - Special case a = 0x80000000, b = 0xFFFFFFFF: lo = 0x80000000, hi = 0 (wraps, no flag).
  - a = 0 gives lo = 0, hi = 0.
- hi/lo are held between operations and change only on the FIX→DONE edge.
- done and div0 are never high in the same cycle.

Test Plan:
- MULT a = 7, b = 0xFFFFFFFD (−3) → done exactly 33 cycles after the start edge; hi = 0xFFFFFFFF, lo = 0xFFFFFFEB; busy drops the next cycle.
- MULT a = 0x80000000, b = 0x80000000 → hi = 0x40000000, lo = 0x00000000. MULT a = 0xFFFFFFFF, b = 0xFFFFFFFF → hi = 0, lo = 1.
- DIV a = 0xFFFFFFF9 (−7), b = 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. DIV a = 7, b = 0xFFFFFFFE → lo = 0xFFFFFFFD, hi = 1.
- DIV a = 123, b = 0 → div0 pulses one cycle after the start edge; done is never asserted; hi/lo keep their previous values; busy back to 0 after 2 cycles.
- DIV a = 0x80000000, b = 0xFFFFFFFF → lo = 0x80000000, hi = 0. A start pulse with different operands during RUN is ignored, and the result stays unchanged.
- Deassert reset to 0 at RUN iteration 10 → busy = done = div0 = 0 and hi = lo = 0 immediately. After release, a fresh MULT 3 × 5 → lo = 15, hi = 0 with normal 33-cycle latency.
